pc_fetch_unit: RTL and testbench

Parametrised fetch program-counter unit for the pipelined core. It generalises the plain enable-gated PC register with:
- a configurable width and reset vector;
- prioritised redirect inputs from EX and ID;
- capture of redirects that arrive during a stall;
- a boot cycle, and a flush pulse for the front end.

It sits at the head of IF, drives the instruction-memory address, and takes stall and redirect requests from the hazard unit.

---
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 125 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-PC bundle: stall/redirect requests in, fetch address and status out.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            id_redirect;
  logic [XLEN-1:0] id_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic            redirect_taken;
  logic            redirect_pending;
  logic            misalign;

  // Hazard/control side
  modport master (
    output en, ex_redirect, ex_target, id_redirect, id_target,
    input  pc, pc_plus, pc_valid, redirect_taken, redirect_pending, misalign
  );

  // Fetch PC unit side
  modport slave (
    input  en, ex_redirect, ex_target, id_redirect, id_target,
    output pc, pc_plus, pc_valid, redirect_taken, redirect_pending, misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch program counter with boot cycle, prioritised EX/ID redirects and stall-time capture.
// Define PC_MISALIGN_TRAP_EN to send misaligned redirect targets to TRAP_VEC and pulse misalign.
module pc_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100)
) (
  input  logic               clk,
  input  logic               reset,
  pc_fetch_unit_if.slave     bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

  // Catch configurations that would let the PC leave the aligned grid
  if (((XLEN'(INC) & ~ALIGN_MASK) != '0) || ((TRAP_VEC & ~ALIGN_MASK) != '0)) begin : g_bad_cfg
    $error("pc_fetch_unit: INC and TRAP_VEC must be ALIGN_BITS-aligned");
  end

  typedef enum logic {BOOT, RUN} state_t;
  typedef enum logic {SRC_EX, SRC_ID} src_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            redirect_taken_q;
  logic            pend_valid;
  src_t            pend_src;
  logic [XLEN-1:0] pend_target;

  logic            sel_valid;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] load_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_q;
  logic            sel_misaligned;
`endif

  always_comb begin
    sel_valid  = 1'b1;
    sel_target = '0;
    if (bus.ex_redirect) begin
      sel_target = bus.ex_target;
    end else if (pend_valid) begin
      sel_target = pend_target;
    end else if (bus.id_redirect) begin
      sel_target = bus.id_target;
    end else begin
      sel_valid = 1'b0;
    end
`ifdef PC_MISALIGN_TRAP_EN
    sel_misaligned = (sel_target & ~ALIGN_MASK) != '0;
    load_target    = sel_misaligned ? TRAP_VEC : sel_target;
`else
    load_target    = sel_target & ALIGN_MASK;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= BOOT;
      pc_q             <= RESET_VEC;
      pc_valid_q       <= 1'b0;
      redirect_taken_q <= 1'b0;
      pend_valid       <= 1'b0;
      pend_src         <= SRC_EX;
      pend_target      <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        BOOT: begin
          state            <= RUN;
          pc_valid_q       <= 1'b1;
          redirect_taken_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          misalign_q       <= 1'b0;
`endif
        end
        RUN: begin
          if (bus.en) begin
            pend_valid       <= 1'b0;
            redirect_taken_q <= sel_valid;
            pc_q             <= sel_valid ? load_target : pc_q + XLEN'(INC);
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q       <= sel_valid && sel_misaligned;
`endif
          end else begin
            redirect_taken_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q       <= 1'b0;
`endif
            // EX always wins the slot; ID may only refresh an ID entry or fill an empty one
            if (bus.ex_redirect) begin
              pend_valid  <= 1'b1;
              pend_src    <= SRC_EX;
              pend_target <= bus.ex_target;
            end else if (bus.id_redirect && (!pend_valid || pend_src == SRC_ID)) begin
              pend_valid  <= 1'b1;
              pend_src    <= SRC_ID;
              pend_target <= bus.id_target;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus          = pc_q + XLEN'(INC);
  assign bus.pc_valid         = pc_valid_q;
  assign bus.redirect_taken   = redirect_taken_q;
  assign bus.redirect_pending = pend_valid;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign         = misalign_q;
`else
  assign bus.misalign         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, reset/boot corner sequences, random run against a reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(
    .XLEN(32), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(2), .TRAP_VEC(TRAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the pending slot is a queue holding at most one entry
  typedef struct {
    bit          from_ex;
    logic [31:0] target;
  } pend_t;

  bit          m_booted, m_valid, m_rt, m_mis;
  logic [31:0] m_pc;
  pend_t       m_pend[$];

  task automatic model_reset();
    m_booted = 0; m_valid = 0; m_rt = 0; m_mis = 0;
    m_pc = 32'h0;
    m_pend.delete();
  endtask

  task automatic model_edge(input bit en, input bit exr, input logic [31:0] ext,
                            input bit idr, input logic [31:0] idt);
    bit          have;
    logic [31:0] t;
    if (!m_booted) begin
      m_booted = 1; m_valid = 1; m_rt = 0; m_mis = 0;
      return;
    end
    if (en) begin
      have = 1;
      if (exr)                  t = ext;
      else if (m_pend.size()>0) t = m_pend[0].target;
      else if (idr)             t = idt;
      else begin have = 0; t = 0; end
      m_pend.delete();
      m_rt  = have;
      m_mis = 0;
      if (!have) m_pc = m_pc + 32'd4;
      else if (t % 4 != 0 && TRAP_ON) begin m_pc = TRAP; m_mis = 1; end
      else m_pc = t - (t % 4);
    end else begin
      m_rt = 0; m_mis = 0;
      if (exr) begin
        m_pend.delete();
        m_pend.push_back('{from_ex: 1'b1, target: ext});
      end else if (idr && (m_pend.size() == 0 || !m_pend[0].from_ex)) begin
        m_pend.delete();
        m_pend.push_back('{from_ex: 1'b0, target: idt});
      end
    end
  endtask

  task automatic apply(input bit en, input bit exr, input logic [31:0] ext,
                       input bit idr, input logic [31:0] idt);
    bus.en = en; bus.ex_redirect = exr; bus.ex_target = ext;
    bus.id_redirect = idr; bus.id_target = idt;
    @(posedge clk);
    model_edge(en, exr, ext, idr, idt);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"},       bus.pc,               m_pc);
    check({tag, ".pc_plus"},  bus.pc_plus,          m_pc + 32'd4);
    check({tag, ".valid"},    32'(bus.pc_valid),       32'(m_valid));
    check({tag, ".rt"},       32'(bus.redirect_taken), 32'(m_rt));
    check({tag, ".pend"},     32'(bus.redirect_pending), 32'(m_pend.size() != 0));
    check({tag, ".misalign"}, 32'(bus.misalign),    32'(m_mis));
  endtask

  typedef struct {
    bit          en, exr;
    logic [31:0] ext;
    bit          idr;
    logic [31:0] idt;
    logic [31:0] pc;
    bit          valid, rt, pend, mis;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit en, bit exr, logic [31:0] ext, bit idr, logic [31:0] idt,
                              logic [31:0] pc, bit valid, bit rt, bit pend, bit mis);
    tbl.push_back('{en:en, exr:exr, ext:ext, idr:idr, idt:idt,
                    pc:pc, valid:valid, rt:rt, pend:pend, mis:mis});
  endfunction

  initial begin
    //  en ex ext           id idt     -> pc                         v  rt pend mis
    add(1, 0, 32'h0,        0, 32'h0,   32'h0,                      1, 0, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h4,                      1, 0, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h8,                      1, 0, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'hC,                      1, 0, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h10,                     1, 0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,   32'h10,                     1, 0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,   32'h10,                     1, 0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,   32'h10,                     1, 0, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h14,                     1, 0, 0, 0);
    add(1, 1, 32'h200,      1, 32'h300, 32'h200,                    1, 1, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h204,                    1, 0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h80,  32'h204,                    1, 0, 1, 0);
    add(0, 1, 32'h40,       0, 32'h0,   32'h204,                    1, 0, 1, 0);
    add(0, 0, 32'h0,        1, 32'h90,  32'h204,                    1, 0, 1, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h40,                     1, 1, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h44,                     1, 0, 0, 0);
    add(1, 1, 32'h103,      0, 32'h0,   32'h100,                    1, 1, 0, TRAP_ON);
    add(1, 0, 32'h0,        0, 32'h0,   32'h104,                    1, 0, 0, 0);
    add(1, 1, 32'hFFFF_FFFC,0, 32'h0,   32'hFFFF_FFFC,              1, 1, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h0,                      1, 0, 0, 0);
    add(1, 0, 32'h0,        1, 32'h2A2, TRAP_ON ? TRAP : 32'h2A0,   1, 1, 0, TRAP_ON);
    add(0, 0, 32'h0,        1, 32'h50,  TRAP_ON ? TRAP : 32'h2A0,   1, 0, 1, 0);
    add(0, 1, 32'h60,       1, 32'h70,  TRAP_ON ? TRAP : 32'h2A0,   1, 0, 1, 0);
    add(1, 0, 32'h0,        1, 32'h90,  32'h60,                     1, 1, 0, 0);
    add(0, 1, 32'h120,      0, 32'h0,   32'h60,                     1, 0, 1, 0);
    add(1, 1, 32'h130,      0, 32'h0,   32'h130,                    1, 1, 0, 0);
    add(1, 0, 32'h0,        0, 32'h0,   32'h134,                    1, 0, 0, 0);

    bus.en = 0; bus.ex_redirect = 0; bus.ex_target = 0;
    bus.id_redirect = 0; bus.id_target = 0;
    reset = 1'b0;
    model_reset();
    #12;
    check("reset.pc",    bus.pc,                   32'h0);
    check("reset.valid", 32'(bus.pc_valid),        32'h0);
    check("reset.rt",    32'(bus.redirect_taken),  32'h0);
    check("reset.pend",  32'(bus.redirect_pending),32'h0);
    check("reset.mis",   32'(bus.misalign),        32'h0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].exr, tbl[i].ext, tbl[i].idr, tbl[i].idt);
      check($sformatf("vec%0d.pc", i),      bus.pc,                    tbl[i].pc);
      check($sformatf("vec%0d.pc_plus", i), bus.pc_plus,               tbl[i].pc + 32'd4);
      check($sformatf("vec%0d.valid", i),   32'(bus.pc_valid),         32'(tbl[i].valid));
      check($sformatf("vec%0d.rt", i),      32'(bus.redirect_taken),   32'(tbl[i].rt));
      check($sformatf("vec%0d.pend", i),    32'(bus.redirect_pending), 32'(tbl[i].pend));
      check($sformatf("vec%0d.mis", i),     32'(bus.misalign),         32'(tbl[i].mis));
    end

    // Reset mid-stall with a pending redirect: clears asynchronously, between edges
    apply(0, 0, 32'h0, 1, 32'h80);
    check("midrst.pend_before", 32'(bus.redirect_pending), 32'h1);
    #3 reset = 1'b0;
    #1;
    check("midrst.pc",    bus.pc,                    32'h0);
    check("midrst.pend",  32'(bus.redirect_pending), 32'h0);
    check("midrst.valid", 32'(bus.pc_valid),         32'h0);
    model_reset();
    #1 reset = 1'b1;

    // Redirect offered on the boot edge is ignored
    apply(1, 1, 32'h500, 1, 32'h600);
    check("boot.pc",    bus.pc,                    32'h0);
    check("boot.valid", 32'(bus.pc_valid),         32'h1);
    check("boot.rt",    32'(bus.redirect_taken),   32'h0);
    check("boot.pend",  32'(bus.redirect_pending), 32'h0);
    apply(1, 0, 32'h0, 0, 32'h0);
    check("boot.next_pc", bus.pc, 32'h4);

    for (int n = 0; n < 600; n++) begin
      bit          en, exr, idr;
      logic [31:0] ext, idt;
      en  = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 6) == 0);
      idr = ($urandom_range(0, 4) == 0);
      ext = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      idt = $urandom;
      apply(en, exr, ext, idr, idt);
      compare_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
